seg_display_scan: RTL and testbench
===================================

# seg_display_scan

Parametrised multiplexed 7-segment display driver for the calculator datapath: takes a binary ALU result plus a display mode, converts it to BCD with a sequential double-dabble engine, and time-multiplexes DIGITS common-anode digits. Sits between the ALU result/control outputs and the board's anode/segment pins. Compared with the fixed four-digit driver, it adds arbitrary width and digit count, a load/busy handshake, and overflow detection. It also adds a programmable decimal-point position, and anodes and segments that switch on the same edge, so the display does not ghost.

## Interface
- DATA_W, 11, width of the unsigned magnitude input.
- DIGITS, 4, number of display digits; digit 0 is rightmost.
- PRESC_W, 12, refresh prescaler width; the scan advances one digit every 2^PRESC_W clocks.
- DP_W, 2, width of dot_pos; must satisfy 2^DP_W >= DIGITS.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; captures data, mode and dot_pos when busy=0.
- data  in  DATA_W  unsigned magnitude.
- mode  in  2  0 unsigned, 1 negative (minus sign), 2 error, 3 fixed-point.
- dot_pos  in  DP_W  digit index that lights its dot in mode 3.
- busy  out  1  conversion in progress; load is ignored while high.
- anodes  out  DIGITS  active-low one-cold digit enable.
- segments  out  8  active-low; bit 7 is the dot, bits 6:0 are the glyph.

## Operation
- Glyphs (bits 6:0):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - minus=0111111, E=0000110, blank=1111111
- Conversion FSM:
  - IDLE: load with busy=0 captures inputs, clears the BCD register, goes to SHIFT.
  - SHIFT: exactly DATA_W cycles, one double-dabble step per cycle (add 3 to each nibble >=5, then shift left with the next data MSB).
  - COMMIT: 1 cycle; writes the display shadow (BCD digits, mode, dot_pos, overflow flag), then returns to IDLE.
- BCD register holds the full range of 2^DATA_W-1 (4*ceil(DATA_W*log10 2) bits).
- Overflow is set if any nonzero BCD digit falls outside the available positions:
  - modes 0 and 3 have DIGITS positions;
  - mode 1 has DIGITS-1 positions, because the leftmost digit carries the sign.
- Shadow rendering per digit i:
  - overflow, or mode 2: digit 0 shows E; other digits show 0.
  - mode 1: digit DIGITS-1 shows minus; others show BCD digit i.
  - modes 0 and 3: BCD digit i.
  - dot is lit only in mode 3 at i==dot_pos.
- Scan:
  - a prescaler counter free-runs; on wrap, the digit index increments modulo DIGITS.
  - anodes and segments are registered from the same index on the same edge.
- The shadow changes only in COMMIT, so the display never shows a partial conversion.

## Timing
- Reset values:
  - anodes all 1, segments 8'hFF, busy 0, FSM IDLE.
  - digit index 0, prescaler 0.
  - shadow = value 0, mode 0, overflow 0.
- First digit drive: on the first prescaler wrap after reset release, anodes drives digit 0 low.
- load sampled at edge T:
  - busy is high from T+1 through T+DATA_W+1 (DATA_W+1 cycles).
  - the shadow updates at edge T+DATA_W+1, when COMMIT ends.
  - busy low at T+DATA_W+2.
- load while busy=1: ignored, no queueing. load in the same cycle busy falls: ignored; it is accepted only when busy is sampled 0.
- The new shadow value appears on the pins at the next digit update, at most 2^PRESC_W cycles later.
- Index wrap: from DIGITS-1 back to 0. The index is a non-power-of-two counter when DIGITS is not a power of 2.
- rst_n asserted mid-conversion aborts it immediately; the shadow returns to its reset contents.
- dot_pos >= DIGITS lights no dot.

## Configuration
- SEG_BLANK_EN defined: leading-zero blanking. Zero digits to the left of the most significant nonzero digit show blank, except:
  - digit 0 always shows;
  - in mode 3, digits at or right of dot_pos always show;
  - the minus sign stays in digit DIGITS-1;
  - in error display, the non-E digits blank.
- Undefined: all leading zeros are displayed.

## Test plan
(DATA_W=11, DIGITS=4, PRESC_W=2)
- Reset: rst_n=0 -> anodes=1111, segments=8'hFF, busy=0. Release, then 4 clocks -> anodes=1110, segments=8'hC0 ("0").
- load data=1234, mode 0 -> busy high exactly 12 cycles. The scan then shows:
  - anodes 1110, segments 8'h99 (4)
  - anodes 1101, segments 8'hB0 (3)
  - anodes 1011, segments 8'hA4 (2)
  - anodes 0111, segments 8'hF9 (1)
- load data=57, mode 1 -> digit 3 = 8'hBF (minus); digits 2..0 = 0,5,7. With SEG_BLANK_EN, digit 2 = 8'hFF.
- load data=1500, mode 3, dot_pos=2 -> digit 2 = 8'h12 (5 with dot); all other digits have bit 7 = 1.
- load data=2047, mode 1 -> overflow: digit 0 = 8'h86 (E), others 8'hC0. Same data in mode 0 displays 2047.
- load during busy, then rst_n pulse mid-conversion -> the second load has no effect; after reset the display shows 0 and busy=0.

Source files
------------

// File: rtl/seg_display_scan.sv
// -----------------------------------------------------------------------------
// seg_display_scan
//
// Multiplexed common-anode 7-segment driver for the calculator datapath.
// A load strobe captures an unsigned magnitude, a display mode and a decimal
// point position. A sequential double-dabble engine converts the magnitude to
// BCD one bit per clock. The finished result is committed to a display shadow
// in a single cycle, so the scan never shows a partially converted value. The
// scan register drives anodes and segments from the same digit index on the
// same edge, so a digit never shows the glyph that belongs to its neighbour.
//
// Parameters
//   DATA_W  : width of the unsigned magnitude input
//   DIGITS  : number of display digits (digit 0 is rightmost)
//   PRESC_W : refresh prescaler width; one digit step every 2^PRESC_W clocks
//   DP_W    : width of dot_pos (2^DP_W >= DIGITS)
//
// Ports
//   clk      in   system clock, all logic on posedge
//   rst_n    in   asynchronous active-low reset
//   load     in   single-cycle strobe, accepted only while busy is low
//   data     in   unsigned magnitude [DATA_W-1:0]
//   mode     in   0 unsigned, 1 negative, 2 error, 3 fixed-point
//   dot_pos  in   digit index whose dot lights in mode 3
//   busy     out  conversion in progress (load ignored)
//   anodes   out  active-low one-cold digit enables [DIGITS-1:0]
//   segments out  active-low, bit 7 = dot, bits 6:0 = glyph
//
// Build option
//   SEG_BLANK_EN : when defined, leading zeros are blanked. Digit 0, digits
//                  at or right of the dot in mode 3, and the minus sign are
//                  never blanked.
// -----------------------------------------------------------------------------
module seg_display_scan #(
    parameter int DATA_W  = 11,
    parameter int DIGITS  = 4,
    parameter int PRESC_W = 12,
    parameter int DP_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    input  logic [DP_W-1:0]   dot_pos,
    output logic              busy,
    output logic [DIGITS-1:0] anodes,
    output logic [7:0]        segments
);

    // Decimal digits needed for 2^DATA_W-1: ceil(DATA_W * log10(2)).
    localparam int BCD_N = (DATA_W * 30103 + 99999) / 100000;
    localparam int BCD_W = 4 * BCD_N;
    localparam int ALL_N = (BCD_N > DIGITS) ? BCD_N : DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef SEG_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam logic [6:0] G_ZERO  = 7'b1000000;
    localparam logic [6:0] G_MINUS = 7'b0111111;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    function automatic logic [6:0] glyph_of(input logic [3:0] d);
        case (d)
            4'd0:    glyph_of = 7'b1000000;
            4'd1:    glyph_of = 7'b1111001;
            4'd2:    glyph_of = 7'b0100100;
            4'd3:    glyph_of = 7'b0110000;
            4'd4:    glyph_of = 7'b0011001;
            4'd5:    glyph_of = 7'b0010010;
            4'd6:    glyph_of = 7'b0000010;
            4'd7:    glyph_of = 7'b1111000;
            4'd8:    glyph_of = 7'b0000000;
            4'd9:    glyph_of = 7'b0010000;
            default: glyph_of = 7'b1111111;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Conversion engine
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] data_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  bcd_d;
    logic [BCD_W-1:0]  bcd_adj;
    logic [1:0]        cap_mode_q;
    logic [DP_W-1:0]   cap_dot_q;
    logic [BCD_N-1:0]  ovf_hit;
    logic              ovf_d;

    // Display shadow: only written in COMMIT.
    logic [BCD_W-1:0]  sh_bcd_q;
    logic [1:0]        sh_mode_q;
    logic [DP_W-1:0]   sh_dot_q;
    logic              sh_ovf_q;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_N; gi++) begin : g_dabble
            logic [3:0] nib;
            assign nib = bcd_q[4*gi +: 4];
            assign bcd_adj[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;

            // A nonzero digit beyond the usable positions is an overflow.
            // The leftmost display digit is unusable in mode 1 (minus sign).
            if (gi >= DIGITS) begin : g_ovf_out
                assign ovf_hit[gi] = (nib != 4'd0);
            end else if (gi == DIGITS - 1) begin : g_ovf_sign
                assign ovf_hit[gi] = (nib != 4'd0) && (cap_mode_q == 2'd1);
            end else begin : g_ovf_none
                assign ovf_hit[gi] = 1'b0;
            end
        end
    endgenerate

    // Shift the adjusted BCD left, pulling in the next magnitude MSB. The
    // discarded top bit is always zero for a legal conversion.
    assign bcd_d = BCD_W'({bcd_adj, data_q[DATA_W-1]});
    assign ovf_d = |ovf_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            data_q     <= '0;
            bcd_q      <= '0;
            cap_mode_q <= 2'd0;
            cap_dot_q  <= '0;
            sh_bcd_q   <= '0;
            sh_mode_q  <= 2'd0;
            sh_dot_q   <= '0;
            sh_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        data_q     <= data;
                        cap_mode_q <= mode;
                        cap_dot_q  <= dot_pos;
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_q  <= bcd_d;
                    data_q <= data_q << 1;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    sh_bcd_q  <= bcd_q;
                    sh_mode_q <= cap_mode_q;
                    sh_dot_q  <= cap_dot_q;
                    sh_ovf_q  <= ovf_d;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;

    // -------------------------------------------------------------------------
    // Shadow rendering
    // -------------------------------------------------------------------------
    logic [3:0]       dig [ALL_N];
    logic [ALL_N-1:0] lz;          // digit and everything to its left are zero
    logic [7:0]       seg_all [DIGITS];

    generate
        for (gi = 0; gi < ALL_N; gi++) begin : g_dig
            if (gi < BCD_N) begin : g_real
                assign dig[gi] = sh_bcd_q[4*gi +: 4];
            end else begin : g_pad
                assign dig[gi] = 4'd0;
            end
        end
    endgenerate

`ifdef SEG_BLANK_EN
    always_comb begin
        lz = '0;
        lz[ALL_N-1] = (dig[ALL_N-1] == 4'd0);
        for (int j = ALL_N - 2; j >= 0; j--) begin
            lz[j] = lz[j+1] && (dig[j] == 4'd0);
        end
    end
`else
    assign lz = '0;
`endif

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_render
            localparam bit IS_LSD = (gi == 0);
            localparam bit IS_MSD = (gi == DIGITS - 1);
            logic [6:0] glyph;
            logic       blank;
            logic       dot;

            always_comb begin
                glyph = glyph_of(dig[gi]);
                blank = 1'b0;
                if (sh_ovf_q || (sh_mode_q == 2'd2)) begin
                    glyph = IS_LSD ? G_E : G_ZERO;
                    blank = BLANK_EN && !IS_LSD;
                end else if ((sh_mode_q == 2'd1) && IS_MSD) begin
                    glyph = G_MINUS;
                end else begin
                    // Digits at or right of the point must show in mode 3.
                    blank = lz[gi] && !IS_LSD &&
                            !((sh_mode_q == 2'd3) && (int'(sh_dot_q) >= gi));
                end
            end

            assign dot = (sh_mode_q == 2'd3) && !sh_ovf_q && (int'(sh_dot_q) == gi);
            assign seg_all[gi] = {~dot, blank ? G_BLANK : glyph};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Scan: the current index is driven on the wrap edge, then advanced, so the
    // first wrap after reset lights digit 0.
    // -------------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DIGITS-1:0]  anodes_q;
    logic [DIGITS-1:0]  anodes_d;
    logic [7:0]         segments_q;

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_anode
            assign anodes_d[gi] = (idx_q != IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            anodes_q   <= '1;
            segments_q <= 8'hFF;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (&presc_q) begin
                anodes_q   <= anodes_d;
                segments_q <= seg_all[idx_q];
                idx_q      <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end
        end
    end

    assign anodes   = anodes_q;
    assign segments = segments_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scan
//
// Scenario tasks push the expected per-digit (anodes, segments) pairs onto a
// scoreboard queue when they drive a load, then pop and compare them as the
// scan presents each digit.
// -----------------------------------------------------------------------------
module tb_seg_display_scan;

    localparam int DATA_W  = 11;
    localparam int DIGITS  = 4;
    localparam int PRESC_W = 2;
    localparam int DP_W    = 2;

`ifdef SEG_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0;
    localparam logic [7:0] S4 = 8'h99, S5 = 8'h92, S7 = 8'hF8;
    localparam logic [7:0] SMINUS = 8'hBF, SE = 8'h86, S5DOT = 8'h12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic [1:0]        mode = 2'd0;
    logic [DP_W-1:0]   dot_pos = '0;
    logic              busy;
    logic [DIGITS-1:0] anodes;
    logic [7:0]        segments;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];

    seg_display_scan #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS),
        .PRESC_W(PRESC_W),
        .DP_W   (DP_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .data    (data),
        .mode    (mode),
        .dot_pos (dot_pos),
        .busy    (busy),
        .anodes  (anodes),
        .segments(segments)
    );

    always #5 clk = ~clk;

    // Leading-zero position: blank when blanking is built in.
    function automatic logic [7:0] lead(input logic [7:0] s);
        return BLANK ? 8'hFF : s;
    endfunction

    task automatic push4(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
        sb.push_back('{an: 4'b1110, seg: d0});
        sb.push_back('{an: 4'b1101, seg: d1});
        sb.push_back('{an: 4'b1011, seg: d2});
        sb.push_back('{an: 4'b0111, seg: d3});
    endtask

    // Pulse load, then count cycles with busy high (bounded).
    task automatic do_load(input logic [DATA_W-1:0] d, input logic [1:0] m,
                           input logic [DP_W-1:0] dp, output int ncyc);
        @(negedge clk);
        load = 1'b1; data = d; mode = m; dot_pos = dp;
        @(negedge clk);
        load = 1'b0;
        ncyc = 0;
        while (busy && ncyc < 200) begin
            ncyc++;
            @(negedge clk);
        end
    endtask

    // Align to a fresh digit-0 update, then pop and compare one entry per digit.
    task automatic collect(input string tag);
        exp_t       e;
        logic [3:0] prev;
        bit         hit;
        int         k;
        hit  = 1'b0;
        prev = anodes;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (anodes == 4'b1110 && prev != 4'b1110) begin
                hit = 1'b1;
                break;
            end
            prev = anodes;
        end
        if (!hit) begin
            checks++; failures++;
            $display("FAIL %s align: anodes=%b, required a fresh 1110 within 64 cycles", tag, anodes);
            sb.delete();
            return;
        end
        k = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (anodes !== e.an || segments !== e.seg) begin
                failures++;
                $display("FAIL %s digit%0d: got anodes=%b segments=%h, required anodes=%b segments=%h",
                         tag, k, anodes, segments, e.an, e.seg);
            end else begin
                $display("[%0t] %s digit%0d anodes=%b segments=%h ok", $time, tag, k, anodes, segments);
            end
            k++;
            if (sb.size() > 0) begin
                hit  = 1'b0;
                prev = anodes;
                for (int c = 0; c < 16; c++) begin
                    @(negedge clk);
                    if (anodes !== prev) begin
                        hit = 1'b1;
                        break;
                    end
                end
                if (!hit) begin
                    checks++; failures++;
                    $display("FAIL %s scan: anodes stuck at %b, required a digit step within 16 cycles", tag, anodes);
                    sb.delete();
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (anodes !== 4'b1111) begin failures++; $display("FAIL reset_anodes: got %b required 1111", anodes); end
        checks++;
        if (segments !== 8'hFF) begin failures++; $display("FAIL reset_segments: got %h required ff", segments); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (anodes !== 4'b1111) begin failures++; $display("FAIL pre_wrap_anodes: got %b required 1111", anodes); end
        @(negedge clk);
        checks++;
        if (anodes !== 4'b1110 || segments !== S0) begin
            failures++;
            $display("FAIL first_digit: got anodes=%b segments=%h required anodes=1110 segments=c0", anodes, segments);
        end
        $display("[%0t] reset first digit anodes=%b segments=%h", $time, anodes, segments);
    endtask

    task automatic test_unsigned();
        int n;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b required 0", busy); end
        push4(S4, S3, S2, S1);
        do_load(11'd1234, 2'd0, 2'd0, n);
        checks++;
        if (n != DATA_W + 1) begin failures++; $display("FAIL busy_len: got %0d cycles required %0d", n, DATA_W + 1); end
        $display("[%0t] load 1234 mode0 busy_cycles=%0d", $time, n);
        collect("unsigned_1234");
    endtask

    task automatic test_negative();
        int n;
        push4(S7, S5, lead(S0), SMINUS);
        do_load(11'd57, 2'd1, 2'd0, n);
        collect("negative_57");
    endtask

    task automatic test_fixed_point();
        int n;
        push4(S0, S0, S5DOT, S1);
        do_load(11'd1500, 2'd3, 2'd2, n);
        collect("fixed_1500_dp2");
    endtask

    task automatic test_overflow();
        int n;
        push4(SE, lead(S0), lead(S0), lead(S0));
        do_load(11'd2047, 2'd1, 2'd0, n);
        collect("overflow_neg_2047");
        push4(S7, S4, S0, S2);
        do_load(11'd2047, 2'd0, 2'd0, n);
        collect("unsigned_2047");
    endtask

    task automatic test_error();
        int n;
        push4(SE, lead(S0), lead(S0), lead(S0));
        do_load(11'd5, 2'd2, 2'd0, n);
        collect("error_mode");
    endtask

    // Loads during busy and on the COMMIT cycle are both dropped.
    task automatic test_back_to_back();
        int n;
        push4(S2, S4, lead(S0), lead(S0));
        @(negedge clk);
        load = 1'b1; data = 11'd42; mode = 2'd0; dot_pos = 2'd0;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 4 || n == DATA_W + 1) begin
                load = 1'b1; data = 11'd999; mode = 2'd1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        checks++;
        if (n != DATA_W + 1) begin failures++; $display("FAIL b2b_busy_len: got %0d cycles required %0d", n, DATA_W + 1); end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_no_queue: busy=%b required 0", busy); end
        $display("[%0t] back_to_back busy_cycles=%0d busy_after=%b", $time, n, busy);
        collect("back_to_back_42");
    endtask

    task automatic test_reset_mid();
        push4(S0, lead(S0), lead(S0), lead(S0));
        @(negedge clk);
        load = 1'b1; data = 11'd1234; mode = 2'd0;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b required 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || anodes !== 4'b1111 || segments !== 8'hFF) begin
            failures++;
            $display("FAIL mid_reset: got busy=%b anodes=%b segments=%h required 0 1111 ff", busy, anodes, segments);
        end
        $display("[%0t] reset mid-conversion busy=%b anodes=%b", $time, busy, anodes);
        @(negedge clk);
        rst_n = 1'b1;
        collect("after_mid_reset");
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b required 0", busy); end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_negative();
        test_fixed_point();
        test_overflow();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
